// File: rtl/rv_decode_stage_pkg.sv
// rtl/rv_decode_stage_pkg.sv - shared RV32/64 opcode, function and immediate-format definitions
package rv_decode_stage_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [2:0] FUNC_ADD = 3'b000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [4:0] opcode;
        logic [2:0] fun;
        logic       shifter_sign;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_we;
        logic       illegal;
    } dec_fields_t;

endpackage

// File: rtl/rv_decode_stage_if.sv
// rtl/rv_decode_stage_if.sv - fetch/execute/register-file signals of the decode stage
interface rv_decode_stage_if #(parameter int XLEN = 32);
    logic            f_valid;
    logic            f_ready;
    logic [31:0]     f_ir;
    logic [XLEN-1:0] f_pc;
    logic            x_ready;
    logic            x_kill;
    logic            x_valid;
    logic [XLEN-1:0] x_pc;
    logic [4:0]      x_rs1;
    logic [4:0]      x_rs2;
    logic [4:0]      x_rd;
    logic [4:0]      x_opcode;
    logic [2:0]      x_fun;
    logic            x_shifter_sign;
    logic [XLEN-1:0] x_imm;
    logic            x_rs1_used;
    logic            x_rs2_used;
    logic            x_rd_we;
    logic            x_illegal;
    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;

    modport slave (
        input  f_valid, f_ir, f_pc, x_ready, x_kill,
        output f_ready, x_valid, x_pc, x_rs1, x_rs2, x_rd, x_opcode, x_fun,
               x_shifter_sign, x_imm, x_rs1_used, x_rs2_used, x_rd_we, x_illegal,
               rf_rs1, rf_rs2
    );

    modport master (
        output f_valid, f_ir, f_pc, x_ready, x_kill,
        input  f_ready, x_valid, x_pc, x_rs1, x_rs2, x_rd, x_opcode, x_fun,
               x_shifter_sign, x_imm, x_rs1_used, x_rs2_used, x_rd_we, x_illegal,
               rf_rs1, rf_rs2
    );
endinterface

// File: rtl/rv_decode_stage_insn_decode.sv
// rtl/rv_decode_stage_insn_decode.sv - combinational field, immediate, usage and legality decode
module rv_insn_decode
    import rv_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir_i,
    output dec_fields_t     fields_o,
    output logic [XLEN-1:0] imm_o
);
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        known;
    logic        illegal;
    logic        no_rs1;
    imm_fmt_e    fmt;
    logic [31:0] imm32;

    assign opc = ir_i[6:2];
    assign f3  = ir_i[14:12];
    assign f7  = ir_i[31:25];

    always_comb begin
        known = 1'b1;
        fmt   = IMM_NONE;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            OPC_MISC_MEM, OPC_OP, OPC_SYSTEM: fmt = IMM_NONE;
            default:                        known = 1'b0;
        endcase
    end

    assign illegal = (ir_i[1:0] != 2'b11) || !known
                   || (opc == OPC_BRANCH && (f3 == 3'b010 || f3 == 3'b011))
                   || (opc == OPC_OP_IMM && f3 == 3'b001 && f7 != 7'h00)
                   || (opc == OPC_OP_IMM && f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);

    // Every format is built as a 32-bit value whose bit 31 is the sign, then widened.
    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{ir_i[31]}}, ir_i[31:20]};
            IMM_S:   imm32 = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            IMM_B:   imm32 = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            IMM_U:   imm32 = {ir_i[31:12], 12'h000};
            IMM_J:   imm32 = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

    assign no_rs1 = (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL);

    always_comb begin
        fields_o              = '0;
        fields_o.rs1          = ir_i[19:15];
        fields_o.rs2          = ir_i[24:20];
        fields_o.rd           = ir_i[11:7];
        fields_o.opcode       = opc;
        fields_o.fun          = (no_rs1 || opc == OPC_JALR) ? FUNC_ADD : f3;
        fields_o.shifter_sign = ir_i[30];
        fields_o.illegal      = illegal;
        fields_o.rs1_used     = !illegal && !no_rs1;
        fields_o.rs2_used     = !illegal && (opc == OPC_STORE || opc == OPC_BRANCH || opc == OPC_OP);
        fields_o.rd_we        = !illegal && (ir_i[11:7] != 5'd0)
                              && (no_rs1 || opc == OPC_JALR || opc == OPC_LOAD
                                  || opc == OPC_OP_IMM || opc == OPC_OP || opc == OPC_SYSTEM);
    end
endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered decode stage with one-entry skid buffer
module rv_decode_stage
    import rv_decode_stage_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC_FILL = '0
) (
    input logic             clk_i,
    input logic             rst_n_i,
    rv_decode_stage_if.slave bus
);
    logic            f_ready_q;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     skid_ir_q, skid_ir_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            x_valid_q, x_valid_d;
    logic [XLEN-1:0] x_pc_q, x_pc_d;
    logic [XLEN-1:0] x_imm_q, x_imm_d;
    dec_fields_t     x_dec_q, x_dec_d;

    logic            in_fire;
    logic            load_x;
    logic [31:0]     nxt_ir;
    logic [XLEN-1:0] nxt_pc;
    logic [XLEN-1:0] nxt_imm;
    dec_fields_t     nxt_dec;

    assign in_fire = bus.f_valid && f_ready_q;
    assign load_x  = !x_valid_q || bus.x_ready;

    // The skid entry is always older than the input, so it wins the X slot.
    assign nxt_ir = skid_valid_q ? skid_ir_q : bus.f_ir;
    assign nxt_pc = skid_valid_q ? skid_pc_q : bus.f_pc;

    rv_insn_decode #(.XLEN(XLEN)) u_dec (
        .ir_i     (nxt_ir),
        .fields_o (nxt_dec),
        .imm_o    (nxt_imm)
    );

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_ir_d    = skid_ir_q;
        skid_pc_d    = skid_pc_q;
        x_valid_d    = x_valid_q;
        x_pc_d       = x_pc_q;
        x_imm_d      = x_imm_q;
        x_dec_d      = x_dec_q;
        if (bus.x_kill) begin
            skid_valid_d = 1'b0;
            x_valid_d    = 1'b0;
        end else begin
            if (load_x) begin
                if (skid_valid_q || in_fire) begin
                    x_valid_d    = 1'b1;
                    x_pc_d       = nxt_pc;
                    x_imm_d      = nxt_imm;
                    x_dec_d      = nxt_dec;
                    skid_valid_d = 1'b0;
                end else begin
                    x_valid_d = 1'b0;
                end
            end
            if (in_fire && !load_x) begin
                skid_valid_d = 1'b1;
                skid_ir_d    = bus.f_ir;
                skid_pc_d    = bus.f_pc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_ready_q    <= 1'b1;
            skid_valid_q <= 1'b0;
            skid_ir_q    <= '0;
            skid_pc_q    <= '0;
            x_valid_q    <= 1'b0;
            x_pc_q       <= RESET_PC_FILL;
            x_imm_q      <= '0;
            x_dec_q      <= '0;
        end else begin
            f_ready_q    <= !skid_valid_d;
            skid_valid_q <= skid_valid_d;
            skid_ir_q    <= skid_ir_d;
            skid_pc_q    <= skid_pc_d;
            x_valid_q    <= x_valid_d;
            x_pc_q       <= x_pc_d;
            x_imm_q      <= x_imm_d;
            x_dec_q      <= x_dec_d;
        end
    end

    assign bus.f_ready        = f_ready_q;
    assign bus.x_valid        = x_valid_q;
    assign bus.x_pc           = x_pc_q;
    assign bus.x_imm          = x_imm_q;
    assign bus.x_rs1          = x_dec_q.rs1;
    assign bus.x_rs2          = x_dec_q.rs2;
    assign bus.x_rd           = x_dec_q.rd;
    assign bus.x_opcode       = x_dec_q.opcode;
    assign bus.x_fun          = x_dec_q.fun;
    assign bus.x_shifter_sign = x_dec_q.shifter_sign;
    assign bus.x_rs1_used     = x_dec_q.rs1_used;
    assign bus.x_rs2_used     = x_dec_q.rs2_used;
    assign bus.x_rd_we        = x_dec_q.rd_we;
    assign bus.x_illegal      = x_dec_q.illegal;

    // Synchronous RF reads launched now return alongside whatever X holds next cycle.
    assign bus.rf_rs1 = load_x ? nxt_dec.rs1 : x_dec_q.rs1;
    assign bus.rf_rs2 = load_x ? nxt_dec.rs2 : x_dec_q.rs2;
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, parametrised successor to the combinational predecode path.
- Accepts fetched instructions over a valid/ready handshake and decodes register fields, the ALU function and one format-selected immediate.
- Flags illegal encodings and holds results in an output register plus a one-entry skid buffer, so fetch never sees a combinational ready path.
- Sits between fetch and execute; drives synchronous register-file read addresses aligned to the X register.

Parameters:
- XLEN, 32, datapath/PC width (32 or 64); immediates are sign-extended to XLEN.
- RESET_PC_FILL, 0, value loaded into x_pc_o at reset.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- f_valid_i  in  1  fetch holds a valid instruction
- f_ready_o  out  1  stage can accept
- f_ir_i  in  32  instruction word
- f_pc_i  in  XLEN  instruction PC
- x_ready_i  in  1  execute accepts the current X entry
- x_kill_i  in  1  flush all held and incoming instructions
- x_valid_o  out  1  X register holds an instruction
- x_pc_o  out  XLEN  PC of the X instruction
- x_rs1_o, x_rs2_o, x_rd_o  out  5 each  register fields
- x_opcode_o  out  5  ir[6:2]
- x_fun_o  out  3  ALU function
- x_shifter_sign_o  out  1  ir[30]
- x_imm_o  out  XLEN  selected immediate
- x_rs1_used_o, x_rs2_used_o, x_rd_we_o  out  1 each  operand usage
- x_illegal_o  out  1  illegal encoding
- rf_rs1_o, rf_rs2_o  out  5 each  register-file read addresses

Behaviour:
- Reset: x_valid_o=0, skid empty, f_ready_o=1, all data outputs 0, x_pc_o=RESET_PC_FILL. Reset is asynchronous on assertion and takes effect immediately mid-operation.
- f_ready_o = !skid_valid, driven only from a register. Transfers:
  - in_fire = f_valid_i & f_ready_o
  - out_fire = x_valid_o & x_ready_i
  - load_x = !x_valid_o | x_ready_i
- When load_x: the X register takes the skid entry if the skid is valid (skid then empties), else takes the input if in_fire, else x_valid_o goes to 0.
- When in_fire and !load_x: the input is written into the skid.
- Only the skid entry can be in flight, so no input is lost. Latency is 1 cycle input-to-X when unstalled; throughput is 1 per cycle.
- x_kill_i has priority over everything. Next cycle x_valid_o=0 and the skid is empty; an input accepted in the kill cycle is discarded; f_ready_o=1.
- rf_rs1_o/rf_rs2_o:
  - When load_x: ir[19:15]/ir[24:20] of the entry about to load (skid if valid, else f_ir_i).
  - Otherwise: the held X instruction.
  - Synchronous RF data therefore always matches the X entry.
- Decode is combinational on the selected next entry and registered into X.
- x_fun_o = 000 for JAL, JALR, LUI, AUIPC; otherwise ir[14:12].
- Immediate select:
  - I: OP_IMM, LOAD, JALR
  - S: STORE
  - B: BRANCH, bit 0 = 0
  - U: LUI, AUIPC; ir[31:12]<<12, sign-extended from bit 31
  - J: JAL, bit 0 = 0
  - all other opcodes: 0
- rs1_used: all except LUI, AUIPC, JAL.
- rs2_used: STORE, BRANCH, OP.
- rd_we: (LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, SYSTEM) and rd!=0.
- Illegal when any of:
  - ir[1:0]!=11
  - opcode outside {LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM}
  - BRANCH with funct3 010/011
  - OP_IMM funct3=001 with ir[31:25]!=0
  - OP_IMM funct3=101 with ir[31:25] not 0x00/0x20
- An illegal entry still flows normally with x_illegal_o=1, x_rd_we_o=0, x_rs1_used_o=0 and x_rs2_used_o=0.

Decomposition:
- Opcode constants (OPC_*), FUNC_ADD and a new 3-bit immediate-format enum (IMM_I/S/B/U/J/NONE) go in the shared rv_defs header.
- One combinational sub-module, rv_insn_decode (ir, XLEN in; fields, imm, usage and illegal out), is instantiated once on the next-entry mux.
- The handshake, skid and X registers stay in rv_decode_stage.

Test Plan:
- Reset then f_valid_i=1 with ir=0x00500093 (addi x1,x0,5), x_ready_i=1.
  - Next cycle: x_valid_o=1, x_imm_o=5, x_rd_o=1, x_fun_o=000, x_rd_we_o=1, rf_rs1_o was 0 in the load cycle.
- Stall: x_ready_i=0 while two instructions are offered.
  - The second is held in the skid and f_ready_o drops to 0.
  - With x_ready_i=1 the instructions exit in order on consecutive cycles and f_ready_o returns to 1.
- Immediates:
  - ir=0xFE000EE3 (beq, offset -4) -> x_imm_o=0xFFFFFFFC.
  - ir=0x800000B7 (lui) with XLEN=64 -> 0xFFFFFFFF80000000.
  - jal ir=0x0080006F -> 8 with x_fun_o=000.
- Kill with X and skid both full and f_valid_i=1 -> next cycle x_valid_o=0, f_ready_o=1; no killed instruction ever appears.
- Illegal encodings: ir=0x00000000, 0x00002063 (branch funct3 010) and 0x40001093 (slli with ir[30] set) -> x_illegal_o=1, x_rd_we_o=0.
- rf address alignment: apply a back-to-back stall/release sequence and check that every time X changes, the previous-cycle rf_rs1_o/rf_rs2_o equal the new x_rs1_o/x_rs2_o.
